// File: rtl/acc_cpu_sequencer.sv
// Multi-cycle control sequencer for the 8-bit accumulator core: owns the PC,
// fetches and decodes instructions, and strobes the ALU and register file.
module acc_cpu_sequencer #(
    parameter logic [3:0] PC_RESET    = 4'd5,
    parameter int         DIV_TIMEOUT = 15
) (
    input  logic       main_clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       step_mode,
    input  logic       step,
    output logic [3:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic [3:0] alu_op,
    output logic [3:0] alu_sub,
    output logic       alu_go,
    input  logic       alu_done,
    output logic       rf_we,
    output logic [3:0] pc,
    output logic       halted,
    output logic       fault,
    output logic [7:0] retired
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] EXEC  = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] NEXT  = 3'd4;
    localparam logic [2:0] PAUSE = 3'd5;
    localparam logic [2:0] HALT  = 3'd6;

    localparam logic [3:0] TIMER_LAST = 4'(DIV_TIMEOUT - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [3:0] link_q, link_d;
    logic [3:0] timer_q, timer_d;
    logic [7:0] retired_q, retired_d;
    logic       fault_q, fault_d;
    logic       go_dec, we_dec;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        link_d    = link_q;
        timer_d   = timer_q;
        retired_d = retired_q;
        fault_d   = fault_q;
        go_dec    = 1'b0;
        we_dec    = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) state_d = FETCH;
            end
            FETCH: begin
                ir_d    = imem_data;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = NEXT;
                case (ir_q[7:4])
                    4'h4: begin
                        go_dec  = 1'b1;
                        timer_d = 4'd0;
                        state_d = WAIT;
                    end
                    4'hA: we_dec = 1'b1;
                    // Land one short of the target so NEXT's increment reaches it.
                    4'h8: begin
                        link_d = pc_q;
                        pc_d   = ir_q[3:0] - 4'd1;
                    end
                    4'hB: pc_d = link_q;
                    4'hC, 4'hD, 4'hE: ;
                    4'hF: begin
                        if (ir_q[3:0] == 4'hF) state_d = HALT;
                    end
                    default: go_dec = 1'b1;
                endcase
            end
            WAIT: begin
                if (alu_done) begin
                    state_d = NEXT;
                end else if (timer_q == TIMER_LAST) begin
                    fault_d = 1'b1;
                    state_d = HALT;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
            NEXT: begin
                pc_d      = pc_q + 4'd1;
                retired_d = retired_q + 8'd1;
                state_d   = step_mode ? PAUSE : FETCH;
            end
            PAUSE: begin
                if (step) state_d = FETCH;
            end
            HALT: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge main_clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= PC_RESET;
            ir_q      <= 8'd0;
            link_q    <= 4'd0;
            timer_q   <= 4'd0;
            retired_q <= 8'd0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            link_q    <= link_d;
            timer_q   <= timer_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
        end
    end

    // Strobes are gated by reset so a reset landing in EXEC cannot fire the datapath.
    assign alu_go    = go_dec & rst_n;
    assign rf_we     = we_dec & rst_n;
    assign alu_op    = ir_q[7:4];
    assign alu_sub   = ir_q[3:0];
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign halted    = (state_q == HALT);
    assign fault     = fault_q;
    assign retired   = retired_q;

endmodule
